example_core_example_arbiter: RTL

Round-robin arbiter and sequencer that shares one `example_core_example_module` datapath instance among NUM_REQ requesters. It accepts at most one request per cycle, drives the shared core, and tracks each issued request through the core's fixed latency with an ID pipeline. It steers each result back to the requester that issued it, and supports a clean enable/drain sequence. It sits between the requester-side fabric and the wrapped core.

---
 rtl/example_core_example_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/example_core_example_arbiter.sv
// Round-robin arbiter that shares one fixed-latency core among NUM_REQ requesters and routes results back.
// Latency: accept -> core_issue_o 1 cycle, -> rsp_valid_o 1+CORE_LATENCY cycles; one request per cycle sustained.
// Backpressure: requesters are held off by the one-hot req_ready_o grant; responses are never stalled.
module example_core_example_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int CORE_LATENCY = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          core_issue_o,
  output logic [DATA_WIDTH-1:0]         core_data_o,
  input  logic [DATA_WIDTH-1:0]         core_data_i,
  input  logic                          core_valid_i,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic                          busy_o,
  output logic                          error_o
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int MW   = $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } slot_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  // Slot 0 is the issue register (mirrors core_issue_o); slot CORE_LATENCY is the
  // tail that lines up with the core's valid_out.
  slot_t [CORE_LATENCY:0] pipe;
  slot_t                 issue_slot;
  slot_t                 tail;
  logic [CORE_LATENCY:0] slot_vld;
  logic                  in_flight;
  // Cycles left during which core_valid_i may still carry results issued before reset.
  logic [MW-1:0]         mask_cnt;

  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  logic                  gnt_found;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W:0]         scan_sum;
  logic [ID_W-1:0]       scan_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_data_arr[gi] = req_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar gs = 0; gs <= CORE_LATENCY; gs++) begin : g_slot_vld
    assign slot_vld[gs] = pipe[gs].vld;
  end

  assign tail           = pipe[CORE_LATENCY];
  assign in_flight      = |slot_vld;
  assign busy_o         = (state != IDLE) || in_flight;
  assign core_issue_o   = pipe[0].vld;
  assign grant_id_o     = gnt_id;
  assign issue_slot.vld = gnt_found;
  assign issue_slot.id  = gnt_id;

  // Round-robin scan from rr_ptr upward with wrap; first valid requester wins, only in RUN.
  always_comb begin
    req_ready_o = '0;
    gnt_found   = 1'b0;
    gnt_id      = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    if (state == RUN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
        if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
          scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
        end
        scan_idx = scan_sum[ID_W-1:0];
        if (!gnt_found && req_valid_i[scan_idx]) begin
          gnt_found = 1'b1;
          gnt_id    = scan_idx;
        end
      end
      if (gnt_found) begin
        req_ready_o[gnt_id] = 1'b1;
      end
    end
  end

  // Steer the core result to the requester recorded at the pipeline tail.
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    if (tail.vld) begin
      rsp_valid_o[tail.id] = 1'b1;
      rsp_data_o           = core_data_i;
    end
  end

  // Sequencer FSM, grant pointer, issue register, ID pipeline and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      pipe        <= '0;
      core_data_o <= '0;
      error_o     <= 1'b0;
      mask_cnt    <= MW'(CORE_LATENCY);
    end else begin
      pipe <= {pipe[CORE_LATENCY-1:0], issue_slot};
      if (gnt_found) begin
        core_data_o <= req_data_arr[gnt_id];
        rr_ptr      <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
      end
      if (mask_cnt != '0) begin
        mask_cnt <= mask_cnt - MW'(1);
      end else if (core_valid_i != tail.vld) begin
        error_o <= 1'b1;
      end
      case (state)
        IDLE:    if (enable_i)   state <= RUN;
        RUN:     if (!enable_i)  state <= DRAIN;
        DRAIN:   if (!in_flight) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
